// File: rtl/ddu_pkg.sv
// Shared types and constants for the DDU read-responder / seven-segment display.
// Contents: FSM state type, blank/dash segment patterns, active-low hex font.
package ddu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    // Segment order {dp,g,f,e,d,c,b,a}, active-low, dp off
    localparam logic [7:0] HEX_FONT [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
// Ports: nibble (4-bit digit value), seg_c (8-bit {dp,g,f,e,d,c,b,a}, active-low).
module hex7seg
    import ddu_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg_c
);

    assign seg_c = HEX_FONT[nibble];

endmodule

// File: rtl/ddu_seg_display.sv
// DDU read responder and 8-digit multiplexed seven-segment display (clk_500 domain).
// Issues reads on the memory debug port for ddu_addr, captures the returned word and
// shows it (or pc_addr when show_pc=1) on a scanned display.
// Ports:
//   clk_500, rst (synchronous, active-low)
//   ddu_addr, show_pc, pc_addr            : display source selection
//   mem_rd_en, mem_rd_addr, mem_rd_data   : memory debug read port
//   rd_valid                              : captured word belongs to current ddu_addr
//   an, seg                               : active-low digit enables / segments
// Build option: define DDU_ZERO_BLANK_EN to blank leading-zero digits.
module ddu_seg_display
    import ddu_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned REFRESH  = 250,
    parameter int unsigned SCAN_DIV = 1
) (
    input  logic              clk_500,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ddu_addr,
    input  logic              show_pc,
    input  logic [31:0]       pc_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              rd_valid,
    output logic [7:0]        an,
    output logic [7:0]        seg
);

    localparam int unsigned RCW = $clog2(REFRESH);
    localparam int unsigned SDW = $clog2(SCAN_DIV + 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] rd_word;
    logic [RCW-1:0]    ref_cnt;
    logic [1:0]        lat_cnt;
    logic              addr_chg_c;
    logic              refresh_due_c;

    assign addr_chg_c    = (ddu_addr != last_addr);
    assign refresh_due_c = (ref_cnt == RCW'(REFRESH - 1));

    // State register
    always_ff @(posedge clk_500) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (addr_chg_c || !rd_valid || refresh_due_c) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE:   state_nxt = (RD_LAT == 1) ? ST_CAPTURE : ST_WAIT;
            ST_WAIT: begin
                if (lat_cnt == 2'd1) begin
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Read datapath; strobe and address are registered on entry to ISSUE so
    // they are valid together for the whole ISSUE cycle.
    always_ff @(posedge clk_500) begin
        if (!rst) begin
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            last_addr   <= '0;
            rd_valid    <= 1'b0;
            rd_word     <= '0;
            ref_cnt     <= '0;
            lat_cnt     <= '0;
        end else begin
            mem_rd_en <= (state_nxt == ST_ISSUE);
            if (state == ST_IDLE && state_nxt == ST_ISSUE) begin
                mem_rd_addr <= ddu_addr;
                last_addr   <= ddu_addr;
            end

            if (state == ST_ISSUE) begin
                lat_cnt <= 2'(RD_LAT - 1);
            end else if (state == ST_WAIT) begin
                lat_cnt <= lat_cnt - 2'd1;
            end

            if (state == ST_CAPTURE) begin
                ref_cnt <= '0;
            end else if (state == ST_IDLE && !refresh_due_c) begin
                ref_cnt <= ref_cnt + RCW'(1);
            end

            // Stale data is still stored, but flagged invalid
            if (state == ST_CAPTURE) begin
                rd_word  <= mem_rd_data;
                rd_valid <= !addr_chg_c;
            end else if (addr_chg_c) begin
                rd_valid <= 1'b0;
            end
        end
    end

    // Display path
    logic [SDW-1:0] div;
    logic [2:0]     idx;
    logic [2:0]     idx_nxt_c;
    logic           wrap_c;
    logic [31:0]    src_c;
    logic           dash_c;
    logic           blank_c;
    logic [3:0]     nib_c;
    logic [7:0]     font_c;

    assign wrap_c    = (div == SDW'(SCAN_DIV - 1));
    assign idx_nxt_c = !rst ? 3'd0 : (wrap_c ? idx + 3'd1 : idx);
    assign src_c     = show_pc ? pc_addr : 32'(rd_word);
    // rd_valid is being cleared during reset, so treat it as invalid there
    assign dash_c    = !show_pc && (!rd_valid || !rst);
    assign nib_c     = src_c[{idx_nxt_c, 2'b00} +: 4];

`ifdef DDU_ZERO_BLANK_EN
    assign blank_c = !dash_c && (idx_nxt_c != 3'd0)
                     && ((src_c >> {idx_nxt_c, 2'b00}) == 32'd0);
`else
    assign blank_c = 1'b0;
`endif

    hex7seg u_hex7seg (
        .nibble (nib_c),
        .seg_c  (font_c)
    );

    // Scan divider and index
    always_ff @(posedge clk_500) begin
        if (!rst) begin
            div <= '0;
            idx <= 3'd0;
        end else begin
            div <= wrap_c ? '0 : div + SDW'(1);
            idx <= idx_nxt_c;
        end
    end

    // an and seg share one edge so no digit ever shows its neighbour's pattern
    always_ff @(posedge clk_500) begin
        an  <= blank_c ? 8'hFF : ~(8'(1) << idx_nxt_c);
        seg <= dash_c ? SEG_DASH : (blank_c ? SEG_BLANK : font_c);
    end

endmodule

// File: tb/tb_ddu_seg_display.sv
// Self-checking bench for ddu_seg_display: two instances (RD_LAT=1/SCAN_DIV=1 and
// RD_LAT=3/SCAN_DIV=3) share stimulus and a latency-modelled memory.
`timescale 1ns/1ps
module tb_ddu_seg_display;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REFRESH = 40;
    localparam int unsigned LAT_A   = 1;
    localparam int unsigned DIV_A   = 1;
    localparam int unsigned LAT_B   = 3;
    localparam int unsigned DIV_B   = 3;
    localparam logic [31:0] FILL    = 32'hBAD0BAD0;

    logic              clk_500 = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] ddu_addr;
    logic              show_pc;
    logic [31:0]       pc_addr;
    logic [31:0]       mem [256];

    logic              en_a, en_b, valid_a, valid_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] data_a, data_b;
    logic [7:0]        an_a, an_b, seg_a, seg_b;
    logic [31:0]       pipe_a;
    logic [31:0]       pipe_b [3];

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;

    always #5 clk_500 = ~clk_500;

    ddu_seg_display #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(LAT_A),
                      .REFRESH(REFRESH), .SCAN_DIV(DIV_A)) dut_a (
        .clk_500(clk_500), .rst(rst), .ddu_addr(ddu_addr), .show_pc(show_pc),
        .pc_addr(pc_addr), .mem_rd_en(en_a), .mem_rd_addr(addr_a),
        .mem_rd_data(data_a), .rd_valid(valid_a), .an(an_a), .seg(seg_a));

    ddu_seg_display #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(LAT_B),
                      .REFRESH(REFRESH), .SCAN_DIV(DIV_B)) dut_b (
        .clk_500(clk_500), .rst(rst), .ddu_addr(ddu_addr), .show_pc(show_pc),
        .pc_addr(pc_addr), .mem_rd_en(en_b), .mem_rd_addr(addr_b),
        .mem_rd_data(data_b), .rd_valid(valid_b), .an(an_b), .seg(seg_b));

    // Memory: data appears RD_LAT cycles after the strobe, junk otherwise;
    // ncyc counts edges since reset release (wall-clock for the scan model).
    always @(posedge clk_500) begin
        pipe_a    <= en_a ? mem[addr_a] : FILL;
        pipe_b[0] <= en_b ? mem[addr_b] : FILL;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
        ncyc      <= rst ? ncyc + 1 : 0;
    end
    assign data_a = pipe_a;
    assign data_b = pipe_b[2];

    function automatic logic [7:0] font(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    // Expected digit for a displayed value at scan slot idx
    function automatic void exp_disp(input logic [31:0] src, input int idx,
                                     output logic [7:0] an_e, output logic [7:0] seg_e);
        logic blank;
        blank = 1'b0;
`ifdef DDU_ZERO_BLANK_EN
        blank = (idx != 0) && ((src >> (4 * idx)) == 32'd0);
`endif
        an_e  = blank ? 8'hFF : 8'(~(8'h01 << idx));
        seg_e = blank ? 8'hFF : font(4'((src >> (4 * idx)) & 32'hF));
    endfunction

    task automatic scan_check(input logic [31:0] src, input int n);
        logic [7:0] ea, sa;
        for (int k = 0; k < n; k++) begin
            @(negedge clk_500);
            exp_disp(src, (ncyc / DIV_A) % 8, ea, sa);
            total++;
            if (an_a !== ea) begin bad++; $display("FAIL scan_an_a cyc=%0d got=%h exp=%h", ncyc, an_a, ea); end
            total++;
            if (seg_a !== sa) begin bad++; $display("FAIL scan_seg_a cyc=%0d got=%h exp=%h", ncyc, seg_a, sa); end
            exp_disp(src, (ncyc / DIV_B) % 8, ea, sa);
            total++;
            if (an_b !== ea) begin bad++; $display("FAIL scan_an_b cyc=%0d got=%h exp=%h", ncyc, an_b, ea); end
            total++;
            if (seg_b !== sa) begin bad++; $display("FAIL scan_seg_b cyc=%0d got=%h exp=%h", ncyc, seg_b, sa); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; ddu_addr = 8'h05; show_pc = 1'b0; pc_addr = 32'd0;
        repeat (3) @(negedge clk_500);
        total++; if (en_a !== 1'b0)    begin bad++; $display("FAIL rst_en_a got=%b exp=0", en_a); end
        total++; if (addr_a !== 8'h00) begin bad++; $display("FAIL rst_addr_a got=%h exp=00", addr_a); end
        total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL rst_valid_a got=%b exp=0", valid_a); end
        total++; if (an_a !== 8'hFE)   begin bad++; $display("FAIL rst_an_a got=%h exp=fe", an_a); end
        total++; if (seg_a !== 8'hBF)  begin bad++; $display("FAIL rst_seg_a got=%h exp=bf", seg_a); end
        total++; if (en_b !== 1'b0)    begin bad++; $display("FAIL rst_en_b got=%b exp=0", en_b); end
        total++; if (valid_b !== 1'b0) begin bad++; $display("FAIL rst_valid_b got=%b exp=0", valid_b); end
        total++; if (an_b !== 8'hFE)   begin bad++; $display("FAIL rst_an_b got=%h exp=fe", an_b); end
        total++; if (seg_b !== 8'hBF)  begin bad++; $display("FAIL rst_seg_b got=%h exp=bf", seg_b); end
    endtask

    task automatic test_first_read();
        rst = 1'b1;
        @(negedge clk_500);
        total++; if (en_a !== 1'b1)    begin bad++; $display("FAIL first_strobe_a got=%b exp=1", en_a); end
        total++; if (addr_a !== 8'h05) begin bad++; $display("FAIL first_addr_a got=%h exp=05", addr_a); end
        total++; if (en_b !== 1'b1)    begin bad++; $display("FAIL first_strobe_b got=%b exp=1", en_b); end
        @(negedge clk_500);
        total++; if (en_a !== 1'b0)    begin bad++; $display("FAIL first_strobe_len_a got=%b exp=0", en_a); end
        total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL first_early_valid_a got=%b exp=0", valid_a); end
        @(negedge clk_500);
        total++; if (valid_a !== 1'b1) begin bad++; $display("FAIL first_valid_a got=%b exp=1", valid_a); end
        repeat (2) @(negedge clk_500);
        total++; if (valid_b !== 1'b1) begin bad++; $display("FAIL first_valid_b got=%b exp=1", valid_b); end
        scan_check(32'hDEADBEEF, 24);
    endtask

    task automatic test_addr_change();
        logic              found, hit;
        int                strobes;
        logic [ADDR_W-1:0] got;
        found = 1'b0; hit = 1'b0; strobes = 0; got = '0;
        for (int k = 0; k < 2 * REFRESH; k++) begin
            @(negedge clk_500);
            if (en_b) begin found = 1'b1; break; end
        end
        total++; if (!found) begin bad++; $display("FAIL chg_find_strobe got=0 exp=1"); end
        @(negedge clk_500);
        ddu_addr = 8'h06;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_500);
            if (k == 0) begin
                total++;
                if (valid_b !== 1'b0) begin bad++; $display("FAIL chg_valid_drop got=%b exp=0", valid_b); end
            end
            if (en_b) begin strobes++; got = addr_b; end
            if (valid_b) begin hit = 1'b1; break; end
        end
        total++; if (hit !== 1'b1)  begin bad++; $display("FAIL chg_valid_in_8 got=%b exp=1", hit); end
        total++; if (strobes != 1)  begin bad++; $display("FAIL chg_strobe_count got=%0d exp=1", strobes); end
        total++; if (got !== 8'h06) begin bad++; $display("FAIL chg_strobe_addr got=%h exp=06", got); end
        scan_check(mem[6], 24);
    endtask

    task automatic test_refresh();
        logic              found;
        logic [ADDR_W-1:0] got;
        ddu_addr = 8'h05;
        repeat (12) @(negedge clk_500);
        found = 1'b0;
        for (int k = 0; k < 2 * REFRESH; k++) begin
            @(negedge clk_500);
            if (en_a) begin found = 1'b1; break; end
        end
        total++; if (!found) begin bad++; $display("FAIL ref_find_strobe got=0 exp=1"); end
        repeat (2) @(negedge clk_500);
        mem[5] = 32'h1;
        found = 1'b0; got = '0;
        for (int k = 0; k < REFRESH + 2; k++) begin
            @(negedge clk_500);
            if (en_a) begin found = 1'b1; got = addr_a; break; end
        end
        total++; if (!found)        begin bad++; $display("FAIL ref_strobe got=0 exp=1"); end
        total++; if (got !== 8'h05) begin bad++; $display("FAIL ref_addr got=%h exp=05", got); end
        repeat (REFRESH + 12) @(negedge clk_500);
        scan_check(32'h1, 24);
    endtask

    task automatic test_show_pc();
        show_pc = 1'b1; pc_addr = 32'h00400010; ddu_addr = 8'h07;
        @(negedge clk_500);
        scan_check(32'h00400010, 24);
        show_pc = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        logic found;
        repeat (12) @(negedge clk_500);
        found = 1'b0;
        for (int k = 0; k < 2 * REFRESH; k++) begin
            @(negedge clk_500);
            if (en_b) begin found = 1'b1; break; end
        end
        total++; if (!found) begin bad++; $display("FAIL rw_find_strobe got=0 exp=1"); end
        @(negedge clk_500);
        rst = 1'b0;
        @(negedge clk_500);
        total++; if (valid_b !== 1'b0) begin bad++; $display("FAIL rw_valid got=%b exp=0", valid_b); end
        total++; if (an_b !== 8'hFE)   begin bad++; $display("FAIL rw_an got=%h exp=fe", an_b); end
        total++; if (seg_b !== 8'hBF)  begin bad++; $display("FAIL rw_seg got=%h exp=bf", seg_b); end
        total++; if (en_b !== 1'b0)    begin bad++; $display("FAIL rw_en got=%b exp=0", en_b); end
        @(negedge clk_500);
        rst = 1'b1;
        @(negedge clk_500);
        total++; if (en_b !== 1'b1)    begin bad++; $display("FAIL rw_restart got=%b exp=1", en_b); end
        total++; if (addr_b !== 8'h07) begin bad++; $display("FAIL rw_restart_addr got=%h exp=07", addr_b); end
        repeat (10) @(negedge clk_500);
        total++; if (valid_b !== 1'b1) begin bad++; $display("FAIL rw_valid_after got=%b exp=1", valid_b); end
        scan_check(mem[7], 24);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            ddu_addr = 8'($urandom_range(0, 15));
            show_pc  = 1'($urandom_range(0, 1));
            pc_addr  = $urandom;
            repeat (12) @(negedge clk_500);
            total++;
            if (valid_a !== 1'b1 || valid_b !== 1'b1) begin
                bad++; $display("FAIL rand_valid it=%0d got=%b%b exp=11", it, valid_a, valid_b);
            end
            scan_check(show_pc ? pc_addr : mem[ddu_addr], 24);
        end
        show_pc = 1'b0;
    endtask

    task automatic test_scan_div();
        logic       found;
        logic [7:0] prev;
        show_pc = 1'b1; pc_addr = 32'h87654321;
        @(negedge clk_500);
        prev = an_b; found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_500);
            if (an_b == 8'h7F && prev != 8'h7F) begin found = 1'b1; break; end
            prev = an_b;
        end
        total++; if (!found) begin bad++; $display("FAIL div_find_7f got=0 exp=1"); end
        for (int k = 1; k < 3; k++) begin
            @(negedge clk_500);
            total++; if (an_b !== 8'h7F) begin bad++; $display("FAIL div_hold k=%0d got=%h exp=7f", k, an_b); end
        end
        @(negedge clk_500);
        total++; if (an_b !== 8'hFE) begin bad++; $display("FAIL div_wrap got=%h exp=fe", an_b); end
        show_pc = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[5] = 32'hDEADBEEF;
        mem[6] = 32'hCAFE1234;
        test_reset();
        test_first_read();
        test_addr_change();
        test_refresh();
        test_show_pc();
        test_reset_mid_wait();
        test_random();
        test_scan_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
